// File: rtl/handshake_pkg.sv
// Shared encodings for handshake-protocol converters and endpoints.
package handshake_pkg;

  // Transmit-side four-phase FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_e;

  // Protocol identifiers shared by converters and endpoints
  localparam int PULSE       = 1;
  localparam int VALID_READY = 2;
  localparam int HANDSHAKE   = 3;

  // Width of a counter that must be able to hold the value n (at least 1 bit)
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hs_tx_fifo.sv
// Synchronous FIFO; head word read combinationally from storage at the read pointer.
module hs_tx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  push_ok, pop_ok;

  // Extra pointer bit distinguishes full from empty
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all buffered words
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/handshake_tx.sv
// Four-phase req/ack transmitter fed from a valid/ready stream through a small FIFO.
module handshake_tx
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_data,
  output logic                       hs_req,
  input  logic                       hs_ack,
  output logic [DATA_WIDTH-1:0]      hs_data,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       err_timeout,
  input  logic                       err_clr,
  output logic [COUNT_WIDTH-1:0]     xfer_count
);

  localparam int          TW      = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES);

  hs_state_e             state, state_nxt;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head;
  logic [TW-1:0]         tmo_cnt;
  logic                  tmo_hold, tmo_hit, xfer_done;

  // No write-through: a full FIFO refuses even when the FSM pops this cycle
  assign s_ready = !fifo_full;
  assign push    = s_valid && s_ready;

  hs_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next state and FIFO pop; REL goes straight back to REQ when words are waiting
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (hs_ack) state_nxt = REL;
      end
      REL: begin
        if (!hs_ack) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Registered handshake outputs; hs_data loads only on pop so it holds through REL
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_req  <= 1'b0;
      hs_data <= '0;
    end else begin
      hs_req <= (state_nxt == REQ);
      if (pop) hs_data <= head;
    end
  end

  assign busy      = (state != IDLE);
  assign xfer_done = (state == REL) && !hs_ack;

  // Completed four-phase cycles, free-running wrap
  always_ff @(posedge clk) begin
    if (rst)            xfer_count <= '0;
    else if (xfer_done) xfer_count <= xfer_count + 1'b1;
  end

  // Wait timer runs only while parked in REQ/REL; a limit of 0 keeps it idle
  assign tmo_hold = (state != IDLE) && (state_nxt == state);
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && tmo_hold && (tmo_cnt == TMO_LIM - 1'b1);

  // Timeout counter: clears on any state change or in IDLE, saturates at the limit
  always_ff @(posedge clk) begin
    if (rst || !tmo_hold)        tmo_cnt <= '0;
    else if (tmo_cnt != TMO_LIM) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Sticky error; a fresh hit wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)          err_timeout <= 1'b0;
    else if (tmo_hit) err_timeout <= 1'b1;
    else if (err_clr) err_timeout <= 1'b0;
  end

endmodule

// File: tb/tb_handshake_tx.sv
// Randomized bench for handshake_tx against a transaction-level reference model.
module tb_handshake_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int CW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          hs_req;
  logic          hs_ack = 1'b0;
  logic [DW-1:0] hs_data;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          err_timeout;
  logic          err_clr = 1'b0;
  logic [CW-1:0] xfer_count;

  always #5 clk = ~clk;

  handshake_tx #(
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .hs_req      (hs_req),
    .hs_ack      (hs_ack),
    .hs_data     (hs_data),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .xfer_count  (xfer_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: words waiting, word on the wire, and handshake phase
  logic [DW-1:0] q[$];
  logic [DW-1:0] cur = '0;
  bit            inflight = 0;   // a word is between launch and ack fall
  bit            rel = 0;        // req has dropped, waiting for ack to fall
  int            exp_xfer = 0;
  int            w = 0;          // cycles spent waiting in the current phase
  bit            m_err = 0;
  bit            last_acc = 0;

  // Responder knobs
  bit r_en = 1, r_hold = 0;
  int r_cnt = 0, r_up = 0, r_dn = 0;
  int up_lo = 0, up_hi = 0, dn_lo = 0, dn_hi = 0;

  // One clock: capture applied inputs, let the edge pass, check at negedge, then respond
  task automatic cyc();
    logic          a_valid, a_ack, a_clr, a_rst, a_ready;
    logic [DW-1:0] a_data;
    bit            completing, launch, fall;
    int            qn;
    a_valid = s_valid; a_data = s_data; a_ack = hs_ack;
    a_clr = err_clr;   a_rst = rst;     a_ready = s_ready;
    @(negedge clk);
    last_acc = 0;
    if (a_rst) begin
      q.delete(); cur = '0; inflight = 0; rel = 0; exp_xfer = 0; w = 0; m_err = 0;
      hs_ack = 1'b0; r_cnt = 0; r_up = up_lo;
    end else begin
      completing = rel && !a_ack;
      if (completing) begin exp_xfer++; inflight = 0; rel = 0; end
      fall   = inflight && !rel && a_ack;
      qn     = q.size();
      launch = (qn > 0) && !inflight;
      if (fall) rel = 1;
      if (launch) begin cur = q.pop_front(); inflight = 1; end
      if (a_valid && a_ready) begin q.push_back(a_data); last_acc = 1; end
      if (launch || fall || completing || !inflight) begin
        w = 0;
        if (a_clr) m_err = 0;
      end else if (w < TMO) begin
        w++;
        if (w == TMO) m_err = 1;
        else if (a_clr) m_err = 0;
      end else if (a_clr) m_err = 0;
    end
    chk("hs_req",      64'(hs_req),      64'(inflight && !rel));
    chk("hs_data",     64'(hs_data),     64'(cur));
    chk("busy",        64'(busy),        64'(inflight));
    chk("fifo_level",  64'(fifo_level),  64'(q.size()));
    chk("s_ready",     64'(s_ready),     64'(q.size() < DEPTH));
    chk("xfer_count",  64'(xfer_count),  64'(exp_xfer % (1 << CW)));
    chk("err_timeout", 64'(err_timeout), 64'(m_err));
    if (!a_rst && r_en) begin
      if (!hs_ack) begin
        if (hs_req && !r_hold) begin
          if (r_cnt >= r_up) begin
            hs_ack = 1'b1; r_cnt = 0; r_dn = int'($urandom_range(dn_hi, dn_lo));
          end else r_cnt++;
        end else r_cnt = 0;
      end else if (!hs_req) begin
        if (r_cnt >= r_dn) begin
          hs_ack = 1'b0; r_cnt = 0; r_up = int'($urandom_range(up_hi, up_lo));
        end else r_cnt++;
      end
    end
  endtask

  task automatic set_resp(input int ul, input int uh, input int dl, input int dh);
    up_lo = ul; up_hi = uh; dn_lo = dl; dn_hi = dh; r_up = ul;
  endtask

  task automatic do_reset();
    s_valid = 0; err_clr = 0; r_hold = 0; r_en = 1; hs_ack = 0;
    rst = 1; cyc(); rst = 0;
    chk("rst_req",   64'(hs_req),     64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_ready", 64'(s_ready),    64'(1));
    chk("rst_xfer",  64'(xfer_count), 64'(0));
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bit ok;
    ok = 0; s_valid = 1; s_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin cyc(); ok = last_acc; end
    s_valid = 0;
    chk("push_bound", 64'(ok), 64'(1));
  endtask

  task automatic wait_idle(input int max);
    bit done;
    done = 0;
    for (int i = 0; i < max && !done; i++) begin
      cyc();
      done = !inflight && (q.size() == 0) && !hs_ack;
    end
    chk("idle_bound", 64'(done), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    // 1: single word, prompt responder
    set_resp(0, 0, 0, 0);
    do_reset();
    chk("rst_data", 64'(hs_data), 64'(0));
    chk("rst_err",  64'(err_timeout), 64'(0));
    s_valid = 1; s_data = 32'hDEADBEEF; cyc();
    s_valid = 0; cyc();
    chk("t1_req",  64'(hs_req),  64'(1));
    chk("t1_data", 64'(hs_data), 64'hDEADBEEF);
    wait_idle(50);
    chk("t1_xfer", 64'(xfer_count), 64'(1));
    chk("t1_busy", 64'(busy), 64'(0));

    // 2: burst of 6 with a slow ack; FIFO fills, order preserved
    do_reset();
    set_resp(20, 20, 0, 0);
    for (int i = 1; i <= 5; i++) push_word(DW'(i));
    chk("t2_full_ready", 64'(s_ready),    64'(0));
    chk("t2_full_level", 64'(fifo_level), 64'(4));
    push_word(DW'(6));
    wait_idle(400);
    chk("t2_xfer", 64'(xfer_count), 64'(6));

    // 3: no ack -> sticky timeout, transfer still completes, then clear
    do_reset();
    set_resp(0, 0, 0, 0);
    r_hold = 1;
    push_word(32'hA5A5_0003);
    for (int i = 0; i < 12; i++) cyc();
    chk("t3_err", 64'(err_timeout), 64'(1));
    chk("t3_req", 64'(hs_req),      64'(1));
    r_hold = 0;
    wait_idle(50);
    chk("t3_xfer", 64'(xfer_count), 64'(1));
    err_clr = 1; cyc(); err_clr = 0;
    chk("t3_clr", 64'(err_timeout), 64'(0));

    // 4: reset while in REL with 3 words buffered
    do_reset();
    set_resp(0, 0, 40, 40);
    for (int i = 0; i < 4; i++) push_word(DW'(32'h100 + i));
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      reached = rel && (q.size() == 3);
      if (!reached) cyc();
    end
    chk("t4_setup", 64'(reached), 64'(1));
    rst = 1; cyc(); rst = 0;
    chk("t4_req",   64'(hs_req),     64'(0));
    chk("t4_level", 64'(fifo_level), 64'(0));
    chk("t4_xfer",  64'(xfer_count), 64'(0));
    chk("t4_ready", 64'(s_ready),    64'(1));
    set_resp(0, 0, 0, 0);
    push_word(32'h0000_0055);
    wait_idle(50);
    chk("t4_after", 64'(xfer_count), 64'(1));

    // 5: spurious ack in IDLE is ignored, also right as a word launches
    do_reset();
    r_en = 0; hs_ack = 1; cyc();
    hs_ack = 0; cyc(); cyc();
    chk("t5_noreq",  64'(hs_req),     64'(0));
    chk("t5_noxfer", 64'(xfer_count), 64'(0));
    s_valid = 1; s_data = 32'hDEADBEEF; cyc();
    s_valid = 0; hs_ack = 1; cyc();
    chk("t5_req",  64'(hs_req),  64'(1));
    chk("t5_data", 64'(hs_data), 64'hDEADBEEF);
    r_en = 1;
    wait_idle(50);
    chk("t5_xfer", 64'(xfer_count), 64'(1));

    // 6: 17 transfers wrap a 4-bit counter to 1
    do_reset();
    set_resp(0, 0, 0, 0);
    for (int i = 0; i < 17; i++) push_word(DW'($urandom));
    wait_idle(200);
    chk("t6_wrap", 64'(xfer_count), 64'(1));

    // Random traffic with varying responder speed and occasional clears
    do_reset();
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(2, 0))
        0:       set_resp(0, 1, 0, 1);
        1:       set_resp(0, 4, 0, 4);
        default: set_resp(3, 12, 0, 10);
      endcase
      for (int i = 0; i < 100; i++) begin
        s_valid = ($urandom_range(1, 0) == 1);
        s_data  = $urandom;
        err_clr = ($urandom_range(15, 0) == 0);
        cyc();
      end
    end
    s_valid = 0; err_clr = 0;
    set_resp(0, 0, 0, 0);
    wait_idle(400);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
